// File: rtl/button_event_fsm_if.sv
// Debounced button level in, single-cycle button events out.
// master drives the level and consumes events; slave is the event FSM.
interface button_event_fsm_if;
    logic       btn_level;
    logic       press;
    logic       release_evt;
    logic       long_press;
    logic       repeat_evt;
    logic       held;
    logic [1:0] state;

    modport master (
        output btn_level,
        input  press, release_evt, long_press, repeat_evt, held, state
    );

    modport slave (
        input  btn_level,
        output press, release_evt, long_press, repeat_evt, held, state
    );
endinterface

// File: rtl/button_event_fsm.sv
// Button level to press/release/long_press/repeat pulses; AUTO_REPEAT_EN enables repeat.
// Latency: 1 clk from a btn_level edge or hold threshold to its registered pulse.
// Backpressure: none; pulses are single-cycle and must be consumed in the cycle seen.
module button_event_fsm #(
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int CW            = 25
) (
    input  logic              clk,
    input  logic              reset,
    button_event_fsm_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        LONG_CYCLES >= (2 ** CW) || REPEAT_CYCLES >= (2 ** CW)) begin : g_bad_cfg
        $error("button_event_fsm: illegal LONG_CYCLES/REPEAT_CYCLES/CW");
    end

    state_t        st;
    logic [CW-1:0] cnt;
    logic          prev_q;
    logic          press_q, release_q, long_q, repeat_q, held_q;
    logic          rise, fall;

    assign rise = bus.btn_level & ~prev_q;
    assign fall = ~bus.btn_level & prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            cnt       <= '0;
            prev_q    <= 1'b1;   // a button held through reset must not look like a new press
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            prev_q    <= bus.btn_level;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (st)
                IDLE: begin
                    if (rise) begin
                        st      <= PRESSED;
                        cnt     <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        st        <= IDLE;
                        cnt       <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        st     <= HOLD;
                        cnt    <= '0;
                        long_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // release outranks a repeat landing on the same cycle
                    if (fall) begin
                        st        <= IDLE;
                        cnt       <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else begin
`ifdef AUTO_REPEAT_EN
                        if (cnt == CW'(REPEAT_CYCLES - 1)) begin
                            cnt      <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`else
                        cnt <= '0;
`endif
                    end
                end
                default: begin
                    st     <= IDLE;
                    cnt    <= '0;
                    held_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.press       = press_q;
    assign bus.release_evt = release_q;
    assign bus.long_press  = long_q;
    assign bus.repeat_evt  = repeat_q;
    assign bus.held        = held_q;
    assign bus.state       = st;
endmodule

// File: tb/tb_button_event_fsm.sv
// Directed vectors for button_event_fsm with LONG_CYCLES=8, REPEAT_CYCLES=4, CW=4.
module tb_button_event_fsm;
    localparam bit AUTO =
`ifdef AUTO_REPEAT_EN
        1'b1;
`else
        1'b0;
`endif

    // expected vector layout: {press, release, long_press, repeat, held, state[1:0]}
    localparam logic [6:0] Z   = 7'b0000000;
    localparam logic [6:0] PR  = 7'b1000101;
    localparam logic [6:0] P1  = 7'b0000101;
    localparam logic [6:0] REL = 7'b0100000;
    localparam logic [6:0] LP  = 7'b0010110;
    localparam logic [6:0] H2  = 7'b0000110;
    localparam logic [6:0] RP  = 7'b0001110;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [6:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t tbl [0:12];

    button_event_fsm_if bus ();

    button_event_fsm #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CW           (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic b, input logic [6:0] exp, input string nm);
        logic [6:0] act;
        @(negedge clk);
        reset         = r;
        bus.btn_level = b;
        @(posedge clk);
        #1;
        act = {bus.press, bus.release_evt, bus.long_press, bus.repeat_evt, bus.held, bus.state};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (press,rel,long,rpt,held,state)", nm, act, exp);
        end
    endtask

    // Idle cycle, then btn_level held high for n sampled cycles.
    task automatic hold_seq(input int n, input string nm);
        logic [6:0] e;
        cyc(1'b0, 1'b0, Z, {nm, "_pre"});
        for (int i = 0; i < n; i++) begin
            if (i == 0)                                  e = PR;
            else if (i < 8)                              e = P1;
            else if (i == 8)                             e = LP;
            else if (AUTO && ((i - 8) % 4 == 0))         e = RP;
            else                                         e = H2;
            cyc(1'b0, 1'b1, e, $sformatf("%s_i%0d", nm, i));
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.btn_level = 1'b1;

        tbl[0]  = '{1'b0, 1'b0, Z};
        tbl[1]  = '{1'b0, 1'b1, PR};
        tbl[2]  = '{1'b0, 1'b1, P1};
        tbl[3]  = '{1'b0, 1'b1, P1};
        tbl[4]  = '{1'b0, 1'b0, REL};
        tbl[5]  = '{1'b0, 1'b0, Z};
        tbl[6]  = '{1'b0, 1'b1, PR};
        tbl[7]  = '{1'b1, 1'b1, Z};     // reset mid-press: no release
        tbl[8]  = '{1'b0, 1'b1, Z};     // still held after reset: no press
        tbl[9]  = '{1'b0, 1'b0, Z};     // first fall after reset: no release
        tbl[10] = '{1'b0, 1'b1, PR};
        tbl[11] = '{1'b0, 1'b0, REL};
        tbl[12] = '{1'b0, 1'b0, Z};

        // button held through reset and afterwards produces nothing
        for (int i = 0; i < 3; i++)  cyc(1'b1, 1'b1, Z, $sformatf("rst_held_%0d", i));
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, Z, $sformatf("post_rst_held_%0d", i));
        cyc(1'b0, 1'b0, Z, "post_rst_fall");

        for (int i = 0; i < 13; i++)
            cyc(tbl[i].rst, tbl[i].btn, tbl[i].exp, $sformatf("vec%0d", i));

        // fall exactly when the long-press threshold would hit
        cyc(1'b0, 1'b0, Z, "thr_pre");
        cyc(1'b0, 1'b1, PR, "thr_press");
        for (int i = 1; i < 8; i++) cyc(1'b0, 1'b1, P1, $sformatf("thr_cnt%0d", i));
        cyc(1'b0, 1'b0, REL, "thr_fall");
        cyc(1'b0, 1'b0, Z, "thr_idle");

        // long hold: long press, repeats only with AUTO_REPEAT_EN
        hold_seq(30, "long");
        cyc(1'b0, 1'b0, REL, "long_fall");
        cyc(1'b0, 1'b0, Z, "long_idle");

        // fall landing on a repeat boundary: release only
        hold_seq(12, "rptb");
        cyc(1'b0, 1'b0, REL, "rptb_fall");

        // reset while in HOLD, released with button still down
        hold_seq(11, "hrst");
        cyc(1'b1, 1'b1, Z, "hrst_reset");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, Z, $sformatf("hrst_held_%0d", i));
        cyc(1'b0, 1'b0, Z, "hrst_fall");
        cyc(1'b0, 1'b1, PR, "hrst_press");
        cyc(1'b0, 1'b0, REL, "hrst_rel");
        cyc(1'b0, 1'b0, Z, "hrst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
